// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the hazard controller and its helpers.
//   - hz_state_e   : hazard-controller state encodings (2-bit)
//   - REG_ZERO     : architectural zero register address
//   - ID/EX control field widths, so a bubble (all control bits zero) stays
//     the same width as the real ID/EX control bundle
//   - is_load_use  : load-use hazard detection helper
package cpu_pkg;

  typedef enum logic [1:0] {
    HZ_RUN        = 2'd0,
    HZ_LOAD_STALL = 2'd1,
    HZ_MEM_WAIT   = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // ID/EX control bundle layout: EX (RegDst, ALUOp[1:0], ALUSrc),
  // M (MemRead, MemWrite, Branch), WB (RegWrite, MemtoReg).
  localparam int EX_CTRL_W    = 4;
  localparam int M_CTRL_W     = 3;
  localparam int WB_CTRL_W    = 2;
  localparam int ID_EX_CTRL_W = EX_CTRL_W + M_CTRL_W + WB_CTRL_W;
  localparam logic [ID_EX_CTRL_W-1:0] ID_EX_BUBBLE = '0;

  // A load in ID/EX whose destination feeds the instruction in ID.
  // rt only counts when the ID instruction actually reads it; $zero never
  // creates a dependency.
  function automatic logic is_load_use(
    input logic       ex_mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_uses_rt
  );
    return ex_mem_read && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Performance counters for the hazard controller.
// Ports:
//   clk_i, rst_n_i  clock / asynchronous active-low reset
//   stall_i         this cycle the PC did not advance
//   flush_i         this cycle IF/ID was flushed
//   stall_cnt_o     wrapping count of stall cycles
//   flush_cnt_o     wrapping count of flush cycles
module hazard_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_i) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_i) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-side hazard controller for the ID/EX pipeline register. Each cycle it
// chooses between advancing, inserting a bubble, flushing IF/ID, or freezing
// the whole pipe on data-memory wait states.
// Optional feature macro: HAZARD_PERF_CNT_EN adds stall_cnt_o / flush_cnt_o.
// Ports:
//   clk_i, rst_n_i                       clock / async active-low reset
//   IF_ID_RSaddr_i, IF_ID_RTaddr_i       source regs of the ID instruction
//   uses_rt_i                            ID instruction reads rt
//   ID_EX_MemRead_i, ID_EX_RTaddr_i      load info latched in ID/EX
//   branch_taken_i                       branch resolved taken in ID
//   mem_req_i, mem_ready_i               data-memory handshake in MEM
//   pc_write_o, if_id_write_o            PC / IF-ID enables
//   if_id_flush_o, id_ex_bubble_o        IF/ID NOP, ID/EX zero controls
//   pipe_hold_o                          ID/EX, EX/MEM, MEM/WB hold
//   timeout_o                            sticky memory-timeout flag
//   state_o                              current FSM state (debug)
//   stall_cnt_o, flush_cnt_o             perf counters (macro only)
// Handshake: the memory stage is waiting whenever mem_req_i=1 and
// mem_ready_i=0; a cycle with mem_ready_i=1 completes the access and the
// pipe advances in that same cycle.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  IF_ID_RSaddr_i,
  input  logic [4:0]  IF_ID_RTaddr_i,
  input  logic        uses_rt_i,
  input  logic        ID_EX_MemRead_i,
  input  logic [4:0]  ID_EX_RTaddr_i,
  input  logic        branch_taken_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        if_id_write_o,
  output logic        if_id_flush_o,
  output logic        id_ex_bubble_o,
  output logic        pipe_hold_o,
  output logic        timeout_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
`endif
  output logic [1:0]  state_o
);

  localparam logic [2:0] LD_INIT   = 3'(LOAD_LAT - 1);
  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT);

  hz_state_e  state_q, state_d;
  hz_state_e  saved_q, saved_d;   // state to resume after a memory wait
  hz_state_e  cur_state;          // state whose rules apply when not frozen
  logic [2:0] ld_q, ld_d;
  logic [7:0] wait_q, wait_d;
  logic       timeout_q;
  logic       timeout_now;
  logic       load_use;
  logic       mem_wait;

  assign load_use = is_load_use(ID_EX_MemRead_i, ID_EX_RTaddr_i,
                                IF_ID_RSaddr_i, IF_ID_RTaddr_i, uses_rt_i);
  assign mem_wait = mem_req_i & ~mem_ready_i;

  // In MEM_WAIT the released cycle already behaves like the saved state.
  assign cur_state = (state_q == HZ_MEM_WAIT) ? saved_q : state_q;

  assign timeout_now = (state_q == HZ_MEM_WAIT) && mem_wait && (wait_q == TIMEOUT_V);

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= HZ_RUN;
      saved_q   <= HZ_RUN;
      ld_q      <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      ld_q      <= ld_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_q | timeout_now;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    ld_d    = ld_q;
    wait_d  = wait_q;
    if (state_q == HZ_MEM_WAIT && mem_wait) begin
      if (wait_q != TIMEOUT_V) wait_d = wait_q + 8'd1;
    end else if (mem_wait) begin
      // Entering a wait from RUN or LOAD_STALL; ld_cnt is left untouched.
      state_d = HZ_MEM_WAIT;
      saved_d = cur_state;
      wait_d  = 8'd1;
    end else begin
      state_d = cur_state;
      wait_d  = '0;
      case (cur_state)
        HZ_RUN: begin
          // A taken branch squashes the consumer, so no stall is started.
          if (!branch_taken_i && load_use && (LOAD_LAT > 1)) begin
            state_d = HZ_LOAD_STALL;
            ld_d    = LD_INIT;
          end
        end
        HZ_LOAD_STALL: begin
          if (ld_q <= 3'd1) begin
            state_d = HZ_RUN;
            ld_d    = '0;
          end else begin
            ld_d = ld_q - 3'd1;
          end
        end
        default: state_d = HZ_RUN;
      endcase
    end
  end

  // Output decode (Mealy)
  always_comb begin
    pc_write_o     = 1'b0;
    if_id_write_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    pipe_hold_o    = 1'b0;
    if (!rst_n_i) begin
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
    end else if (mem_wait) begin
      pipe_hold_o = 1'b1;
    end else begin
      case (cur_state)
        HZ_RUN: begin
          if (branch_taken_i) begin
            if_id_flush_o = 1'b1;
            pc_write_o    = 1'b1;
            if_id_write_o = 1'b1;
          end else if (load_use) begin
            id_ex_bubble_o = 1'b1;
          end else begin
            pc_write_o    = 1'b1;
            if_id_write_o = 1'b1;
          end
        end
        HZ_LOAD_STALL: id_ex_bubble_o = 1'b1;
        default:       pipe_hold_o    = 1'b1;
      endcase
    end
  end

  assign timeout_o = rst_n_i & (timeout_q | timeout_now);
  assign state_o   = state_q;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_perf (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .stall_i     (~pc_write_o),
    .flush_i     (if_id_flush_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );
`endif

endmodule
